reg_bank_onehot: RTL
====================

REG_BANK_ONEHOT -- requirements
Module: reg_bank_onehot

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width of every register and data port.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the write counter.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- i_clk  in  1  the single clock; all state updates on its rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_rs1_add  in  5  read address, port 1, binary.
- i_rs2_add  in  5  read address, port 2, binary.
- o_data_rs1  out  XLEN  read data, port 1.
- o_data_rs2  out  XLEN  read data, port 2.
- i_addr_wr  in  31  one-hot write mask, bits [31:1].
- i_wr_en  in  1  write strobe from writeback.
- i_wr_data  in  XLEN  write data.
- i_dbg_add  in  5  debug read address, binary.
- o_dbg_data  out  XLEN  registered debug read data.
- o_wr_err  out  1  sticky flag: a multi-hot write mask was seen.
- o_wr_cnt  out  CNT_W  count of committed writes, saturating.

Function
REQ-004 The block SHALL hold 31 registers x1..x31 of XLEN bits; x0 SHALL always read 0 and SHALL never be stored.
REQ-005 A write SHALL commit on the rising edge when i_wr_en=1 and exactly one bit of i_addr_wr is set; register xN (N = index of the set bit) takes i_wr_data.
REQ-006 When i_wr_en=1 and i_addr_wr=0, the block SHALL perform no write, leave o_wr_err unchanged, and leave o_wr_cnt unchanged.
REQ-007 When i_wr_en=1 and two or more bits of i_addr_wr are set, the block SHALL write no register and SHALL set o_wr_err=1 on that edge.
REQ-008 Once set, o_wr_err SHALL stay 1 until reset.
REQ-009 When i_wr_en=0, the block SHALL ignore i_addr_wr and i_wr_data.
REQ-010 o_data_rs1 and o_data_rs2 SHALL be combinational functions of the read address and register contents, with zero-cycle latency.
REQ-011 o_dbg_data SHALL be registered: on each edge it captures the contents of i_dbg_add as they stood before that edge's write, giving one-cycle latency; address 0 gives 0.
REQ-012 o_wr_cnt SHALL increment by 1 on each committed write (REQ-005) and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-013 When both read ports address the same register, both ports SHALL return identical data.

Reset
REQ-014 Asserting i_rstn=0 SHALL immediately, without waiting for a clock edge, force all of the following to 0: registers x1..x31, o_dbg_data, o_wr_err, and o_wr_cnt.
REQ-015 An assertion of i_rstn=0 coincident with a write strobe SHALL discard that write.
REQ-016 The first edge after deassertion SHALL operate normally.

Configuration
REQ-017 When macro REGBANK_BYPASS_EN is defined, each read port SHALL forward i_wr_data combinationally if all of the following hold:
- i_wr_en=1;
- i_addr_wr is one-hot;
- its set bit matches the nonzero read address.
REQ-018 When REGBANK_BYPASS_EN is not defined, read ports SHALL return only stored contents; a same-cycle write becomes visible on the cycle after its edge.
REQ-019 REGBANK_BYPASS_EN SHALL NOT affect o_dbg_data, o_wr_err, or o_wr_cnt.

Verification
REQ-020 Reset-value scenario: i_rstn=0 applied mid-run -> all 31 registers read 0, o_wr_err=0, o_wr_cnt=0, with no clock edge required.
REQ-021 Basic write scenario: i_wr_en=1, i_addr_wr=1<<5 (x5), i_wr_data=32'hDEADBEEF, i_rs1_add=5 -> o_data_rs1=32'hDEADBEEF after the edge; o_wr_cnt=1.
REQ-022 Multi-hot scenario: i_wr_en=1, i_addr_wr=bits 3 and 7 set, i_wr_data=32'h12345678 -> x3 and x7 unchanged, o_wr_err=1 and still 1 ten cycles later, o_wr_cnt unchanged.
REQ-023 x0 and empty-mask scenario: i_rs2_add=0 -> o_data_rs2=0 always; i_wr_en=1 with i_addr_wr=0 -> no register changes, o_wr_cnt unchanged.
REQ-024 Bypass scenario: same-cycle write of 32'hA5A5A5A5 to x9 with i_rs1_add=9 -> o_data_rs1=32'hA5A5A5A5 in that cycle with REGBANK_BYPASS_EN defined, and the old x9 value without it.
REQ-025 Saturation scenario: CNT_W=4, 20 committed writes -> o_wr_cnt=15; debug read of x5 -> new value appears on o_dbg_data exactly one edge after i_dbg_add=5.

Source files
------------

// File: rtl/reg_bank_onehot_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_onehot_if
//  Description : Read, write, debug and status signals of the one-hot
//                register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_bank_onehot_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [4:0]      i_rs1_add;
    logic [4:0]      i_rs2_add;
    logic [XLEN-1:0] o_data_rs1;
    logic [XLEN-1:0] o_data_rs2;
    logic [31:1]     i_addr_wr;
    logic            i_wr_en;
    logic [XLEN-1:0] i_wr_data;
    logic [4:0]      i_dbg_add;
    logic [XLEN-1:0] o_dbg_data;
    logic            o_wr_err;
    logic [CNT_W-1:0] o_wr_cnt;

    modport master (
        output i_rs1_add, i_rs2_add, i_addr_wr, i_wr_en, i_wr_data, i_dbg_add,
        input  o_data_rs1, o_data_rs2, o_dbg_data, o_wr_err, o_wr_cnt
    );

    modport slave (
        input  i_rs1_add, i_rs2_add, i_addr_wr, i_wr_en, i_wr_data, i_dbg_add,
        output o_data_rs1, o_data_rs2, o_dbg_data, o_wr_err, o_wr_cnt
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_onehot
//  Description : 31 x XLEN register file with one-hot write mask, two
//                combinational read ports, registered debug read, sticky
//                multi-hot error flag and saturating write counter.
//                Define REGBANK_BYPASS_EN to forward same-cycle write data
//                onto the read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_onehot #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  wire logic        i_clk,
    input  wire logic        i_rstn,
    reg_bank_onehot_if.slave bus
);
    localparam int c_NUM_REGS = 31;

    logic [XLEN-1:0]  r_regs [1:c_NUM_REGS];
    logic [XLEN-1:0]  w_file [0:c_NUM_REGS];
    logic [XLEN-1:0]  r_dbg_data;
    logic             r_wr_err;
    logic [CNT_W-1:0] r_wr_cnt;

    logic [31:0]      w_mask32;
    logic             w_any;
    logic             w_onehot;
    logic             w_multi;
    logic             w_commit;
    logic             w_cnt_max;

    // Bit 0 is padded so the mask can be indexed directly by a read address.
    assign w_mask32  = {bus.i_addr_wr, 1'b0};
    assign w_any     = |bus.i_addr_wr;
    assign w_onehot  = w_any && ((bus.i_addr_wr & (bus.i_addr_wr - 31'd1)) == 31'd0);
    assign w_multi   = w_any && !w_onehot;
    assign w_commit  = bus.i_wr_en && w_onehot;
    assign w_cnt_max = (r_wr_cnt == {CNT_W{1'b1}});

    // x0 is a hard-wired zero entry, never stored.
    always_comb begin
        w_file[0] = '0;
        for (int i = 1; i <= c_NUM_REGS; i++) begin
            w_file[i] = r_regs[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 1; i <= c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= c_NUM_REGS; i++) begin
                if (w_commit && bus.i_addr_wr[i]) begin
                    r_regs[i] <= bus.i_wr_data;
                end
            end
        end
    end

    // Debug read samples the stored value, so it sees pre-write contents.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_dbg_data <= '0;
            r_wr_err   <= 1'b0;
            r_wr_cnt   <= '0;
        end else begin
            r_dbg_data <= w_file[bus.i_dbg_add];
            if (bus.i_wr_en && w_multi) begin
                r_wr_err <= 1'b1;
            end
            if (w_commit && !w_cnt_max) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
        end
    end

`ifdef REGBANK_BYPASS_EN
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1      = w_commit && w_mask32[bus.i_rs1_add];
    assign w_hit_rs2      = w_commit && w_mask32[bus.i_rs2_add];
    assign bus.o_data_rs1 = w_hit_rs1 ? bus.i_wr_data : w_file[bus.i_rs1_add];
    assign bus.o_data_rs2 = w_hit_rs2 ? bus.i_wr_data : w_file[bus.i_rs2_add];
`else
    logic unused_mask;

    assign unused_mask    = ^w_mask32;
    assign bus.o_data_rs1 = w_file[bus.i_rs1_add];
    assign bus.o_data_rs2 = w_file[bus.i_rs2_add];
`endif

    assign bus.o_dbg_data = r_dbg_data;
    assign bus.o_wr_err   = r_wr_err;
    assign bus.o_wr_cnt   = r_wr_cnt;
endmodule
`default_nettype wire
